axi4lite_slave_mem: RTL and testbench

- Parametrised AXI4-Lite slave memory: the next generation of the team's fixed-width master/slave pair.
- Adds configurable data width and depth, WSTRB byte-lane writes, and SLVERR for out-of-range addresses.
- Adds independent read/write FSMs (AW and W may arrive in either order) and programmable read wait states.
- Sits on the interconnect as a generic register/scratch memory target.

---
 rtl/axi4lite_pkg.sv | 18 +
 rtl/axi4lite_byte_ram.sv | 40 ++++
 rtl/axi4lite_slave_mem.sv | 219 +++++++++++++++++++++
 tb/tb_axi4lite_slave_mem.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_pkg.sv
// Shared types and constants for the AXI4-Lite slave memory.
// States are reused by the write FSM (all four) and the read FSM (IDLE/ADDR/RESP).
package axi4lite_pkg;

  localparam int ADDRWIDTH_DEF   = 32;
  localparam int DATAWIDTH_DEF   = 32;
  localparam int MEMADDRBITS_DEF = 12;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} axi_state_e;

  function automatic logic [1:0] resp_code(input logic oor);
    return oor ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4lite_byte_ram.sv
// Single-clock RAM with a byte-enabled write port and a registered read port.
// One 8-bit array per lane so each lane maps onto its own block-RAM column.
module axi4lite_byte_ram #(
  parameter int DATAWIDTH   = 32,
  parameter int MEMADDRBITS = 12
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [DATAWIDTH/8-1:0]   i_be,
  input  logic [MEMADDRBITS-1:0]   i_waddr,
  input  logic [DATAWIDTH-1:0]     i_wdata,
  input  logic                     i_re,
  input  logic [MEMADDRBITS-1:0]   i_raddr,
  output logic [DATAWIDTH-1:0]     o_rdata
);

  localparam int NLANES = DATAWIDTH / 8;
  localparam int DEPTH  = 2 ** MEMADDRBITS;

  genvar gi;
  generate
    for (gi = 0; gi < NLANES; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH];
      logic [7:0] r_rdata;

      // Read-first: a read on the same edge as a write sees the old byte.
      always_ff @(posedge i_clk) begin
        if (i_we && i_be[gi]) begin
          r_mem[i_waddr] <= i_wdata[gi*8 +: 8];
        end
        if (i_re) begin
          r_rdata <= r_mem[i_raddr];
        end
      end

      assign o_rdata[gi*8 +: 8] = r_rdata;
    end
  endgenerate

endmodule

// File: rtl/axi4lite_slave_mem.sv
// AXI4-Lite scratch memory target: independent read/write FSMs, byte strobes,
// SLVERR on out-of-range addresses and a fixed number of read wait states.
module axi4lite_slave_mem
  import axi4lite_pkg::*;
#(
  parameter int ADDRWIDTH   = ADDRWIDTH_DEF,
  parameter int DATAWIDTH   = DATAWIDTH_DEF,
  parameter int MEMADDRBITS = MEMADDRBITS_DEF,
  parameter int RD_WAIT     = 0
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic [ADDRWIDTH-1:0]   AWADDR,
  input  logic [2:0]             AWPROT,
  input  logic                   AWVALID,
  output logic                   AWREADY,
  input  logic [DATAWIDTH-1:0]   WDATA,
  input  logic [DATAWIDTH/8-1:0] WSTRB,
  input  logic                   WVALID,
  output logic                   WREADY,
  output logic [1:0]             BRESP,
  output logic                   BVALID,
  input  logic                   BREADY,
  input  logic [ADDRWIDTH-1:0]   ARADDR,
  input  logic [2:0]             ARPROT,
  input  logic                   ARVALID,
  output logic                   ARREADY,
  output logic [DATAWIDTH-1:0]   RDATA,
  output logic [1:0]             RRESP,
  output logic                   RVALID,
  input  logic                   RREADY
);

  localparam int STRBW = DATAWIDTH / 8;
  localparam int LSB   = $clog2(STRBW);
  localparam int TOP   = MEMADDRBITS + LSB;

  // ---------------- write side ----------------
  axi_state_e              r_wr_state;
  logic                    r_awready;
  logic                    r_wready;
  logic                    r_bvalid;
  logic [1:0]              r_bresp;
  logic [ADDRWIDTH-1:0]    r_awaddr;
  logic [DATAWIDTH-1:0]    r_wdata;
  logic [STRBW-1:0]        r_wstrb;

  logic                    w_aw_hs;
  logic                    w_w_hs;
  logic                    w_commit;
  logic                    w_wr_oor;
  logic [ADDRWIDTH-1:0]    w_wr_addr;
  logic [DATAWIDTH-1:0]    w_wr_data;
  logic [STRBW-1:0]        w_wr_strb;

  assign w_aw_hs = AWVALID && r_awready;
  assign w_w_hs  = WVALID && r_wready;

  // Whichever half arrived earlier comes from its latch, the other live.
  always_comb begin
    w_wr_addr = AWADDR;
    w_wr_data = WDATA;
    w_wr_strb = WSTRB;
    w_commit  = 1'b0;
    case (r_wr_state)
      IDLE: w_commit = w_aw_hs && w_w_hs;
      ADDR: begin
        w_wr_addr = r_awaddr;
        w_commit  = w_w_hs;
      end
      DATA: begin
        w_wr_data = r_wdata;
        w_wr_strb = r_wstrb;
        w_commit  = w_aw_hs;
      end
      default: ;
    endcase
  end

  assign w_wr_oor = |(w_wr_addr >> TOP);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wr_state <= IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
    end else if (w_commit) begin
      r_wr_state <= RESP;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b1;
      r_bresp    <= resp_code(w_wr_oor);
    end else begin
      case (r_wr_state)
        IDLE: begin
          if (w_aw_hs) begin
            r_wr_state <= ADDR;
            r_awaddr   <= AWADDR;
            r_awready  <= 1'b0;
            r_wready   <= 1'b1;
          end else if (w_w_hs) begin
            r_wr_state <= DATA;
            r_wdata    <= WDATA;
            r_wstrb    <= WSTRB;
            r_wready   <= 1'b0;
            r_awready  <= 1'b1;
          end else begin
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
          end
        end
        RESP: begin
          if (BREADY) begin
            r_wr_state <= IDLE;
            r_bvalid   <= 1'b0;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- read side ----------------
  axi_state_e              r_rd_state;
  logic                    r_arready;
  logic                    r_rvalid;
  logic [1:0]              r_rresp;
  logic                    r_rd_oor;
  logic [2:0]              r_rd_cnt;

  logic                    w_ar_hs;
  logic                    w_rd_oor;
  logic [DATAWIDTH-1:0]    w_ram_rdata;

  assign w_ar_hs  = ARVALID && r_arready;
  assign w_rd_oor = |(ARADDR >> TOP);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rd_state <= IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rresp    <= RESP_OKAY;
      r_rd_oor   <= 1'b0;
      r_rd_cnt   <= '0;
    end else begin
      case (r_rd_state)
        IDLE: begin
          if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_rresp   <= resp_code(w_rd_oor);
            r_rd_oor  <= w_rd_oor;
            if (RD_WAIT == 0) begin
              r_rd_state <= RESP;
              r_rvalid   <= 1'b1;
            end else begin
              r_rd_state <= ADDR;
              r_rd_cnt   <= 3'(RD_WAIT);
            end
          end else begin
            r_arready <= 1'b1;
          end
        end
        ADDR: begin
          if (r_rd_cnt == 3'd1) begin
            r_rd_state <= RESP;
            r_rvalid   <= 1'b1;
          end else begin
            r_rd_cnt <= r_rd_cnt - 3'd1;
          end
        end
        RESP: begin
          if (RREADY) begin
            r_rd_state <= IDLE;
            r_rvalid   <= 1'b0;
            r_arready  <= 1'b1;
          end
        end
        default: r_rd_state <= IDLE;
      endcase
    end
  end

  // The RAM output register only reloads on an AR handshake, so it holds
  // the captured word for the whole wait/response period.
  axi4lite_byte_ram #(
    .DATAWIDTH   (DATAWIDTH),
    .MEMADDRBITS (MEMADDRBITS)
  ) u_ram (
    .i_clk   (ACLK),
    .i_we    (w_commit && !w_wr_oor),
    .i_be    (w_wr_strb),
    .i_waddr (w_wr_addr[TOP-1:LSB]),
    .i_wdata (w_wr_data),
    .i_re    (w_ar_hs),
    .i_raddr (ARADDR[TOP-1:LSB]),
    .o_rdata (w_ram_rdata)
  );

  logic w_unused;
  assign w_unused = ^{AWPROT, ARPROT, w_wr_addr[LSB-1:0], ARADDR[LSB-1:0]};

  assign AWREADY = r_awready;
  assign WREADY  = r_wready;
  assign BVALID  = r_bvalid;
  assign BRESP   = r_bresp;
  assign ARREADY = r_arready;
  assign RVALID  = r_rvalid;
  assign RRESP   = r_rresp;
  assign RDATA   = (r_rvalid && !r_rd_oor) ? w_ram_rdata : '0;

endmodule

// File: tb/tb_axi4lite_slave_mem.sv
// Directed bench for axi4lite_slave_mem: default instance plus an RD_WAIT=3 instance.
module tb_axi4lite_slave_mem;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;

  // RD_WAIT=3 instance
  logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0, s_rdata;
  logic [3:0]  s_wstrb = '0;
  logic        s_awvalid = 0, s_wvalid = 0, s_bready = 0, s_arvalid = 0, s_rready = 0;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;

  int errors = 0;
  int checks = 0;

  axi4lite_slave_mem u_dut (
    .ACLK(clk), .ARESETN(rst_n),
    .AWADDR(awaddr), .AWPROT(3'b000), .AWVALID(awvalid), .AWREADY(awready),
    .WDATA(wdata), .WSTRB(wstrb), .WVALID(wvalid), .WREADY(wready),
    .BRESP(bresp), .BVALID(bvalid), .BREADY(bready),
    .ARADDR(araddr), .ARPROT(3'b000), .ARVALID(arvalid), .ARREADY(arready),
    .RDATA(rdata), .RRESP(rresp), .RVALID(rvalid), .RREADY(rready)
  );

  axi4lite_slave_mem #(.RD_WAIT(3)) u_dut_w (
    .ACLK(clk), .ARESETN(rst_n),
    .AWADDR(s_awaddr), .AWPROT(3'b000), .AWVALID(s_awvalid), .AWREADY(s_awready),
    .WDATA(s_wdata), .WSTRB(s_wstrb), .WVALID(s_wvalid), .WREADY(s_wready),
    .BRESP(s_bresp), .BVALID(s_bvalid), .BREADY(s_bready),
    .ARADDR(s_araddr), .ARPROT(3'b000), .ARVALID(s_arvalid), .ARREADY(s_arready),
    .RDATA(s_rdata), .RRESP(s_rresp), .RVALID(s_rvalid), .RREADY(s_rready)
  );

  // Called at a falling edge; returns at a falling edge after the B handshake.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp, output bit ok);
    bit aw_done, w_done, aw_fire, w_fire;
    int n;
    ok = 1'b1;
    resp = 2'b11;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(negedge clk); n++;
      if (aw_fire) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_fire)  begin wvalid  = 1'b0; w_done  = 1'b1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) begin
      ok = 1'b0;
      return;
    end
    bready = 1'b1; n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    if (!bvalid) ok = 1'b0;
    resp = bresp;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output bit ok);
    int n;
    ok = 1'b1;
    data = '1; resp = 2'b11;
    araddr = addr; arvalid = 1'b1; n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    if (!arready) begin
      ok = 1'b0; arvalid = 1'b0;
      return;
    end
    @(negedge clk);
    arvalid = 1'b0;
    rready = 1'b1; n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    if (!rvalid) ok = 1'b0;
    data = rdata; resp = rresp;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || bresp !== 2'b00 ||
        rresp !== 2'b00 || rdata !== 32'h0)
      begin errors++; $display("FAIL reset_outputs: got rdy/valid=%b bresp=%b rresp=%b rdata=%h required all zero",
        {awready, wready, arready, bvalid, rvalid}, bresp, rresp, rdata); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({awready, wready, arready} !== 3'b111)
      begin errors++; $display("FAIL reset_release_ready: got %b required 111", {awready, wready, arready}); end
    $display("test_reset done");
  endtask

  task automatic test_reset_mid_write();
    logic [1:0] resp; logic [31:0] d; bit ok; int n;
    awaddr = 32'h10; awvalid = 1'b1; n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    awvalid = 1'b0;
    checks++;
    if (awready !== 1'b0 || wready !== 1'b1)
      begin errors++; $display("FAIL midwr_addr_state: got awready=%b wready=%b required 0 1", awready, wready); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b0)
      begin errors++; $display("FAIL midwr_in_reset: got aw=%b w=%b bvalid=%b required 0 0 0", awready, wready, bvalid); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (awready !== 1'b1 || wready !== 1'b1 || bvalid !== 1'b0)
      begin errors++; $display("FAIL midwr_after_release: got aw=%b w=%b bvalid=%b required 1 1 0", awready, wready, bvalid); end
    axi_write(32'h10, 32'h12345678, 4'hF, resp, ok);
    checks++;
    if (!ok || resp !== 2'b00)
      begin errors++; $display("FAIL midwr_write: got ok=%0d bresp=%b required 1 00", ok, resp); end
    axi_read(32'h10, d, resp, ok);
    checks++;
    if (!ok || d !== 32'h12345678 || resp !== 2'b00)
      begin errors++; $display("FAIL midwr_readback: got ok=%0d data=%h resp=%b required 1 12345678 00", ok, d, resp); end
    $display("test_reset_mid_write done");
  endtask

  task automatic test_w_before_aw();
    logic [1:0] resp; logic [31:0] d; bit ok; int n;
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1; n = 0;
    while (!wready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    wvalid = 1'b0;
    checks++;
    if (awready !== 1'b1 || wready !== 1'b0)
      begin errors++; $display("FAIL wfirst_data_state: got aw=%b w=%b required 1 0", awready, wready); end
    repeat (2) @(negedge clk);
    awaddr = 32'h40; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0)
      begin errors++; $display("FAIL wfirst_resp: got bvalid=%b bresp=%b aw=%b w=%b required 1 00 0 0",
        bvalid, bresp, awready, wready); end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0)
      begin errors++; $display("FAIL wfirst_bvalid_drop: got %b required 0", bvalid); end
    axi_read(32'h40, d, resp, ok);
    checks++;
    if (!ok || d !== 32'hDEADBEEF || resp !== 2'b00)
      begin errors++; $display("FAIL wfirst_readback: got ok=%0d data=%h resp=%b required 1 deadbeef 00", ok, d, resp); end
    $display("test_w_before_aw done");
  endtask

  task automatic test_strobes();
    logic [1:0] resp; logic [31:0] d; bit ok;
    axi_write(32'h40, 32'h11223344, 4'h5, resp, ok);
    checks++;
    if (!ok || resp !== 2'b00)
      begin errors++; $display("FAIL strobe_write: got ok=%0d bresp=%b required 1 00", ok, resp); end
    axi_read(32'h40, d, resp, ok);
    checks++;
    if (!ok || d !== 32'hDE22BE44)
      begin errors++; $display("FAIL strobe_readback: got ok=%0d data=%h required 1 de22be44", ok, d); end
    axi_write(32'h40, 32'h99999999, 4'h0, resp, ok);
    axi_read(32'h40, d, resp, ok);
    checks++;
    if (!ok || d !== 32'hDE22BE44)
      begin errors++; $display("FAIL strobe_zero: got ok=%0d data=%h required 1 de22be44", ok, d); end
    $display("test_strobes done");
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp; logic [31:0] d; bit ok;
    axi_write(32'h0, 32'hCAFEF00D, 4'hF, resp, ok);
    axi_write(32'h4000, 32'hFFFFFFFF, 4'hF, resp, ok);
    checks++;
    if (!ok || resp !== 2'b10)
      begin errors++; $display("FAIL oor_write_resp: got ok=%0d bresp=%b required 1 10", ok, resp); end
    axi_read(32'h0, d, resp, ok);
    checks++;
    if (!ok || d !== 32'hCAFEF00D)
      begin errors++; $display("FAIL oor_mem_unchanged: got ok=%0d data=%h required 1 cafef00d", ok, d); end
    axi_read(32'h4000, d, resp, ok);
    checks++;
    if (!ok || resp !== 2'b10 || d !== 32'h0)
      begin errors++; $display("FAIL oor_read: got ok=%0d resp=%b data=%h required 1 10 00000000", ok, resp, d); end
    axi_write(32'h3FFC, 32'h0BADCAFE, 4'hF, resp, ok);
    checks++;
    if (!ok || resp !== 2'b00)
      begin errors++; $display("FAIL top_word_write: got ok=%0d bresp=%b required 1 00", ok, resp); end
    axi_read(32'h3FFC, d, resp, ok);
    checks++;
    if (!ok || resp !== 2'b00 || d !== 32'h0BADCAFE)
      begin errors++; $display("FAIL top_word_read: got ok=%0d resp=%b data=%h required 1 00 0badcafe", ok, resp, d); end
    $display("test_out_of_range done");
  endtask

  task automatic test_rd_wait();
    int n;
    s_awaddr = 32'h20; s_wdata = 32'h600DF00D; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1; n = 0;
    while (!(s_awready && s_wready) && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    s_bready = 1'b1; n = 0;
    while (!s_bvalid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (s_bvalid !== 1'b1 || s_bresp !== 2'b00)
      begin errors++; $display("FAIL wait_setup_write: got bvalid=%b bresp=%b required 1 00", s_bvalid, s_bresp); end
    @(negedge clk);
    s_bready = 1'b0;
    s_araddr = 32'h20; s_arvalid = 1'b1; n = 0;
    while (!s_arready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    s_arvalid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (s_rvalid !== 1'b0)
        begin errors++; $display("FAIL wait_rvalid_early: cycle N+%0d got rvalid=%b required 0", k, s_rvalid); end
      @(negedge clk);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (s_rvalid !== 1'b1 || s_rdata !== 32'h600DF00D || s_rresp !== 2'b00)
        begin errors++; $display("FAIL wait_hold: cycle N+%0d got rvalid=%b rdata=%h rresp=%b required 1 600df00d 00",
          k + 4, s_rvalid, s_rdata, s_rresp); end
      @(negedge clk);
    end
    s_rready = 1'b1;
    @(negedge clk);
    s_rready = 1'b0;
    checks++;
    if (s_rvalid !== 1'b0)
      begin errors++; $display("FAIL wait_rvalid_drop: got %b required 0", s_rvalid); end
    $display("test_rd_wait done");
  endtask

  task automatic test_same_edge();
    logic [1:0] resp; logic [31:0] d; bit ok;
    axi_write(32'h8, 32'hAAAAAAAA, 4'hF, resp, ok);
    awaddr = 32'h8; wdata = 32'h55555555; wstrb = 4'hF; araddr = 32'h8;
    checks++;
    if ({awready, wready, arready} !== 3'b111)
      begin errors++; $display("FAIL same_edge_ready: got %b required 111", {awready, wready, arready}); end
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hAAAAAAAA || bvalid !== 1'b1)
      begin errors++; $display("FAIL same_edge_old_data: got rvalid=%b rdata=%h bvalid=%b required 1 aaaaaaaa 1",
        rvalid, rdata, bvalid); end
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    axi_read(32'h8, d, resp, ok);
    checks++;
    if (!ok || d !== 32'h55555555)
      begin errors++; $display("FAIL same_edge_new_data: got ok=%0d data=%h required 1 55555555", ok, d); end
    $display("test_same_edge done");
  endtask

  task automatic test_back_to_back();
    logic [1:0] resp; logic [31:0] d; bit ok;
    for (int i = 0; i < 4; i++) begin
      axi_write(32'h100 + 32'(i * 4), 32'hA5000000 + 32'(i), 4'hF, resp, ok);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(32'h100 + 32'(i * 4), d, resp, ok);
      checks++;
      if (!ok || d !== 32'hA5000000 + 32'(i))
        begin errors++; $display("FAIL b2b_read%0d: got ok=%0d data=%h required 1 %h", i, ok, d, 32'hA5000000 + 32'(i)); end
    end
    $display("test_back_to_back done");
  endtask

  initial begin
    test_reset();
    test_reset_mid_write();
    test_w_before_aw();
    test_strobes();
    test_out_of_range();
    test_rd_wait();
    test_same_edge();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
